display_scheduler: RTL

Time-shares the three-digit seven-segment display between several binary-valued requesters. It round-robin arbitrates among asserted requests and converts the winner's binary value to BCD with an iterative shift-add-3 (double-dabble) datapath. It presents stable `ones`/`ten`/`hund` digits to the display driver for a programmable hold time before moving to the next requester. It sits between the application counters (score, timer, mode) and the BCD-to-segment display driver.

---
 rtl/display_pkg.sv | 37 +++
 rtl/display_scheduler_bcd_iter_conv.sv | 60 ++++++
 rtl/display_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the time-shared seven-segment display scheduler.
package display_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned NDIG    = 3;
   localparam int unsigned MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      COMMIT,
      HOLD
   } state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // Round-robin search starting just after the previous owner; the owner itself is checked last.
   function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                        input logic [2:0]         last,
                                        input int unsigned        nreq);
      rr_pick_t    pick;
      int unsigned cand;
      pick = '0;
      for (int unsigned i = 1; i <= MAX_REQ; i++) begin
         cand = (32'(last) + i) % nreq;
         if (i <= nreq && !pick.found && req[3'(cand)]) begin
            pick.found = 1'b1;
            pick.idx   = 3'(cand);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/display_scheduler_bcd_iter_conv.sv
// Iterative double-dabble binary-to-BCD converter: one shift per clock, DW shifts per value.
module bcd_iter_conv
   import display_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic [DW-1:0]      bin,
   output logic               done,
   output logic [DIGIT_W-1:0] ones,
   output logic [DIGIT_W-1:0] ten,
   output logic [DIGIT_W-1:0] hund
);

   localparam int unsigned SR_W  = DIGIT_W * NDIG + DW;
   localparam int unsigned CNT_W = $clog2(DW);

   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  adj;
   logic [SR_W-1:0]  nxt;
   logic [CNT_W-1:0] cnt;
   logic             running;

   // Add 3 to every BCD nibble of 5 or more before the shift.
   always_comb begin
      adj = sr;
      for (int unsigned d = 0; d < NDIG; d++) begin
         if (sr[DW + d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5))
            adj[DW + d*DIGIT_W +: DIGIT_W] = sr[DW + d*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
      end
   end

   assign nxt  = adj << 1;
   // Flags the final shift so the owner can leave CONVERT on the same edge.
   assign done = running && (cnt == CNT_W'(DW - 1));

   assign ones = sr[DW             +: DIGIT_W];
   assign ten  = sr[DW + DIGIT_W   +: DIGIT_W];
   assign hund = sr[DW + 2*DIGIT_W +: DIGIT_W];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sr      <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         sr      <= SR_W'(bin);
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         sr  <= nxt;
         cnt <= cnt + CNT_W'(1);
         if (done)
            running <= 1'b0;
      end
   end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin display time-sharing: pick a requester, convert its value to BCD, hold the digits.
module display_scheduler
   import display_pkg::*;
#(
   parameter int unsigned DW          = 8,
   parameter int unsigned NREQ        = 3,
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   value,
   output logic [NREQ-1:0]      grant,
   output logic [DIGIT_W-1:0]   ones,
   output logic [DIGIT_W-1:0]   ten,
   output logic [DIGIT_W-1:0]   hund,
   output logic                 bcd_valid,
   output logic                 busy
);

   localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned LGW = $clog2(NREQ);

   state_t             state;
   logic [LGW-1:0]     last_grant;
   logic [HCW-1:0]     hold_cnt;
   rr_pick_t           pick;
   logic               hold_end;
   logic               start;
   logic [DW-1:0]      sel_val;
   logic               conv_done;
   logic [DIGIT_W-1:0] conv_ones;
   logic [DIGIT_W-1:0] conv_ten;
   logic [DIGIT_W-1:0] conv_hund;

   assign pick     = rr_next(MAX_REQ'(req), 3'(last_grant), NREQ);
   assign hold_end = (state == HOLD) && (hold_cnt == HCW'(HOLD_CYCLES - 1));
   assign start    = ((state == IDLE) || hold_end) && pick.found;

   // Winner's value, captured by the converter only on the selection edge.
   always_comb begin
      sel_val = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick.idx == 3'(i))
            sel_val = value[i*DW +: DW];
      end
   end

   bcd_iter_conv #(.DW(DW)) u_conv (
      .CLK   (CLK),
      .RST   (RST),
      .start (start),
      .bin   (sel_val),
      .done  (conv_done),
      .ones  (conv_ones),
      .ten   (conv_ten),
      .hund  (conv_hund)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= LGW'(NREQ - 1);
         hold_cnt   <= '0;
         ones       <= '0;
         ten        <= '0;
         hund       <= '0;
         bcd_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (state == HOLD && !hold_end) begin
                  hold_cnt <= hold_cnt + HCW'(1);
               end else if (pick.found) begin
                  grant      <= NREQ'(1) << pick.idx;
                  last_grant <= LGW'(pick.idx);
                  busy       <= 1'b1;
                  state      <= CONVERT;
               end else begin
                  grant <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            CONVERT: begin
               if (conv_done)
                  state <= COMMIT;
            end
            COMMIT: begin
               ones      <= conv_ones;
               ten       <= conv_ten;
               hund      <= conv_hund;
               bcd_valid <= 1'b1;
               hold_cnt  <= '0;
               state     <= HOLD;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
